// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter
//
// Shares one ALU (control unit plus add/sub, Radix-4 mul and SRT-2 div
// datapath) between N_REQ client blocks. A round-robin pick in IDLE selects a
// winner and latches its op code and operands. START pulses gnt and alu_begin
// for one cycle. RUN feeds alu_inbus from the latched operands on the ALU's
// load strobes and captures alu_outbus one cycle after each push strobe. RESP
// holds the result for the winner until it accepts it with resp_ready.
//
// Parameters:
//   W               operand/result width
//   N_REQ           number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog limit in RUN cycles (watchdog build only)
//
// Ports:
//   clk, reset_input                 clock, synchronous active-high reset
//   req, req_op, req_a/q/m           per-requester request level, op, operands
//   gnt                              one-hot, one-cycle grant pulse
//   resp_valid, resp_ready           one-hot result handshake
//   resp_a, resp_q, resp_err         captured results, watchdog abort flag
//   alu_begin, alu_op, alu_reset     ALU control
//   alu_inbus                        operand bus into the ALU (combinational)
//   alu_load_a/q/m, alu_push_a/q     ALU register-load and push strobes
//   alu_outbus, alu_end              ALU result bus and completion pulse
//
// Configuration macro: ALU_ARB_TIMEOUT_EN enables the RUN watchdog. Without it
// there is no counter, resp_err is constant 0 and alu_reset follows
// reset_input.

module alu_request_arbiter #(
    parameter int W              = 8,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset_input,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [W*N_REQ-1:0] req_a,
    input  logic [W*N_REQ-1:0] req_q,
    input  logic [W*N_REQ-1:0] req_m,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   resp_valid,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [W-1:0]       resp_a,
    output logic [W-1:0]       resp_q,
    output logic               resp_err,
    output logic               alu_begin,
    output logic [1:0]         alu_op,
    output logic               alu_reset,
    output logic [W-1:0]       alu_inbus,
    input  logic               alu_load_a,
    input  logic               alu_load_q,
    input  logic               alu_load_m,
    input  logic               alu_push_a,
    input  logic               alu_push_q,
    input  logic [W-1:0]       alu_outbus,
    input  logic               alu_end
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        RUN   = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick_idx;
    logic [W-1:0]     a_lat;
    logic [W-1:0]     q_lat;
    logic [W-1:0]     m_lat;
    logic             arm_a;
    logic             arm_q;
    logic             timeout_hit;
    logic             winner_ready;

    // Index arithmetic modulo N_REQ, valid for N_REQ that is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return sum[IDX_W-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: scan from the farthest offset down so the last hit,
    // which is the first set bit at or after rr_ptr, is the one that sticks.
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(int'(rr_ptr), i)]) pick_idx = wrap_idx(int'(rr_ptr), i);
        end
    end

    assign winner_ready = resp_ready[winner];

    // Next-state logic. Only the winner's ready bit can end RESP, and RUN ends
    // on the ALU's completion pulse or on a watchdog expiry.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|req) state_next = START;
            START:   state_next = RUN;
            RUN:     if (alu_end || timeout_hit) state_next = RESP;
            RESP:    if (winner_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand bus: the ALU asserts at most one load strobe at a time; if it
    // ever asserts more, A wins over Q and Q over M. Outside RUN the bus idles
    // at 0.
    always_comb begin
        alu_inbus = '0;
        if (state == RUN) begin
            if (alu_load_a)      alu_inbus = a_lat;
            else if (alu_load_q) alu_inbus = q_lat;
            else if (alu_load_m) alu_inbus = m_lat;
        end
    end

    // State register plus all registered outputs. alu_op doubles as the latched
    // op code, since it must hold that value from START through RESP anyway.
    // Results are cleared at START so a register the ALU never pushes reads 0.
    // A push arms a capture and OUTBUS is taken one cycle later, including in
    // the cycle that carries alu_end.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            winner     <= '0;
            a_lat      <= '0;
            q_lat      <= '0;
            m_lat      <= '0;
            arm_a      <= 1'b0;
            arm_q      <= 1'b0;
            gnt        <= '0;
            resp_valid <= '0;
            resp_a     <= '0;
            resp_q     <= '0;
            alu_begin  <= 1'b0;
            alu_op     <= 2'b00;
        end else begin
            state     <= state_next;
            gnt       <= '0;
            alu_begin <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner    <= pick_idx;
                        alu_op    <= req_op[2*pick_idx +: 2];
                        a_lat     <= req_a[W*pick_idx +: W];
                        q_lat     <= req_q[W*pick_idx +: W];
                        m_lat     <= req_m[W*pick_idx +: W];
                        gnt       <= one_hot(pick_idx);
                        alu_begin <= 1'b1;
                    end
                end
                START: begin
                    resp_a <= '0;
                    resp_q <= '0;
                    arm_a  <= 1'b0;
                    arm_q  <= 1'b0;
                end
                RUN: begin
                    arm_a <= alu_push_a;
                    arm_q <= alu_push_q;
                    if (arm_a) resp_a <= alu_outbus;
                    if (arm_q) resp_q <= alu_outbus;
                    if (alu_end) begin
                        resp_valid <= one_hot(winner);
                        arm_a      <= 1'b0;
                        arm_q      <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_valid <= one_hot(winner);
                        resp_a     <= '0;
                        resp_q     <= '0;
                        arm_a      <= 1'b0;
                        arm_q      <= 1'b0;
                    end
                end
                RESP: begin
                    if (winner_ready) begin
                        resp_valid <= '0;
                        rr_ptr     <= wrap_idx(int'(winner), 1);
                        alu_op     <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] run_cnt;
    logic             err_q;

    // run_cnt equals the 1-based index of the current RUN cycle, so the abort
    // reset lands exactly in RUN cycle TIMEOUT_CYCLES. A real alu_end in that
    // same cycle still counts as a normal completion.
    assign timeout_hit = (state == RUN) && !alu_end && (run_cnt == TMO_LIMIT);
    assign alu_reset   = reset_input | timeout_hit;
    assign resp_err    = err_q;

    // Watchdog counter and error flag; the flag lives for one RESP phase.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == START) begin
                run_cnt <= CNT_W'(1);
            end else if ((state == RUN) && (run_cnt != TMO_LIMIT)) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if ((state == RESP) && winner_ready) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    // No watchdog: nothing can abort a run, and resp_err is always 0.
    assign timeout_hit = 1'b0;
    assign alu_reset   = reset_input;
    assign resp_err    = (TIMEOUT_CYCLES < 0);
`endif

endmodule
